desloc_iterativo: RTL
=====================

Name: desloc_iterativo

Overview:
- Sequential shift/rotate unit that consumes the operand and selection outputs of the datapath shift-source/shift-amount multiplexers.
- Captures a 32-bit operand and a 5-bit shift amount on a start request, then applies one bit position per clock until the count is exhausted.
- Reports completion with a one-cycle done pulse; the control FSM waits on done before writing the result back to the register bank.

Parameters:
- WIDTH, 32, operand/result width.
- SHAMT_W, 5, shift-amount width; must satisfy 2**SHAMT_W == WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when not busy.
- op  in  3  operation code, sampled with start.
- n  in  SHAMT_W  shift amount, sampled with start.
- entrada  in  WIDTH  operand, sampled with start.
- saida  out  WIDTH  result register.
- busy  out  1  high while shifting.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset is asynchronous and active-high, with one clock, clk. While reset is high: saida=0, busy=0, done=0, count=0, state=IDLE. Reset asserted mid-operation aborts the operation with no partial result retained.
- op encoding:
  - 000 NOP
  - 001 LOAD
  - 010 SLL
  - 011 SRL (zero fill)
  - 100 SRA (sign fill from current MSB)
  - 101 ROR
  - 110 ROL
  - 111 reserved
- FSM states:
  - IDLE: waiting for a request.
  - SHIFT: one bit position applied per clock.
  - DONE: result presented with the done pulse.
- Start acceptance:
  - Accepted in IDLE or DONE only.
  - Ignored in SHIFT: no capture, no effect on the operation in flight.
  - Ignored when op is 000 or 111; state and saida are unchanged.
- LOAD accepted at edge E0: saida<=entrada, go to DONE; done high in the cycle after E0.
- Shift/rotate op accepted at E0: saida<=entrada, count<=n, latch op.
  - If n==0: go to DONE; saida equals entrada unchanged.
  - Otherwise: go to SHIFT.
- In SHIFT, each edge:
  - Apply a 1-bit step of the latched op to saida.
  - count<=count-1.
  - The edge on which count goes 1->0 moves to DONE.
- Timing:
  - For amount n>=1, done is high in the cycle after edge En, i.e. n cycles of busy followed by one done cycle.
  - busy is high exactly in SHIFT.
  - done is high exactly in DONE, for one cycle.
  - busy and done are never high together.
- DONE exit:
  - Without start: next edge goes to IDLE.
  - With a valid start: the new request is accepted (back-to-back operation), with the same rules as from IDLE.
- saida holds its value in IDLE/DONE until the next accepted request or reset.
- Width rules:
  - SRA fill is the MSB of saida at each step, so repeated steps replicate the original sign bit.
  - Rotates move bits with no loss, so n steps of ROR equal rotate-right-by-n.
  - Maximum n=31 gives 31 busy cycles.
- entrada, op and n may change freely while busy; only the values captured at acceptance matter.

Decomposition:
- Shared package holds:
  - Op encoding constants (OP_NOP, OP_LOAD, OP_SLL, OP_SRL, OP_SRA, OP_ROR, OP_ROL).
  - FSM state encoding (IDLE, SHIFT, DONE).
  - WIDTH/SHAMT_W defaults, reused by the control unit that drives op.
- One natural sub-module: desloc_passo, purely combinational; given a value and op it returns the value after a 1-bit step. The top block keeps the FSM, counter and result register.

Test Plan:
- LOAD entrada=0xDEADBEEF, start 1 cycle -> saida=0xDEADBEEF and done=1 in the next cycle; busy never asserted.
- SLL entrada=0x0000000F, n=4 -> busy 4 cycles, then done pulse with saida=0x000000F0.
- SRA entrada=0x80000000, n=8 -> done after 8 busy cycles with saida=0xFF800000; SRL with the same inputs -> saida=0x00800000.
- ROR entrada=0x12345678, n=4 -> saida=0x81234567. ROL entrada=0x00000001, n=31 -> 31 busy cycles, then saida=0x80000000.
- SRL n=0, entrada=0xA5A5A5A5 -> no busy, done next cycle, saida unchanged. Start with op=111 or 000 -> no done, saida unchanged. Start during busy with op=LOAD -> ignored, and the original result is still delivered.
- Reset asserted asynchronously at busy cycle 3 of a ROL n=10 -> saida, busy and done go to 0 immediately. A start after release works normally. A back-to-back start in the DONE cycle is accepted.

Source files
------------

// File: rtl/desloc_iterativo_pkg.sv
// desloc_iterativo_pkg: op codes, FSM states and default widths shared by the shifter and its control unit
package desloc_iterativo_pkg;
  localparam int DEF_WIDTH   = 32;
  localparam int DEF_SHAMT_W = 5;
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_SRL  = 3'b011;
  localparam logic [2:0] OP_SRA  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ROL  = 3'b110;
  localparam logic [2:0] OP_RSV  = 3'b111;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/desloc_passo.sv
// desloc_passo: one-bit shift/rotate step of a value for the given op
module desloc_passo
  import desloc_iterativo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] valor,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] resultado
);
  always_comb
    resultado = (op == OP_SLL) ? {valor[WIDTH-2:0], 1'b0} :
                (op == OP_SRL) ? {1'b0, valor[WIDTH-1:1]} :
                (op == OP_SRA) ? {valor[WIDTH-1], valor[WIDTH-1:1]} :
                (op == OP_ROR) ? {valor[0], valor[WIDTH-1:1]} :
                (op == OP_ROL) ? {valor[WIDTH-2:0], valor[WIDTH-1]} :
                valor;
endmodule

// File: rtl/desloc_iterativo.sv
// desloc_iterativo: iterative shifter applying one bit position per clock, with busy/done handshake
module desloc_iterativo
  import desloc_iterativo_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [SHAMT_W-1:0] n,
  input  logic [WIDTH-1:0]   entrada,
  output logic [WIDTH-1:0]   saida,
  output logic               busy,
  output logic               done
);
  state_t state, state_nxt;
  logic [SHAMT_W-1:0] count;
  logic [2:0] op_r;
  logic [WIDTH-1:0] passo;
  logic accept;
  assign accept = start && state != SHIFT && op != OP_NOP && op != OP_RSV;
  desloc_passo #(.WIDTH(WIDTH)) u_passo (.valor(saida), .op(op_r), .resultado(passo));
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = accept ? ((op == OP_LOAD || n == '0) ? DONE : SHIFT) :
                (state == SHIFT) ? ((count == SHAMT_W'(1)) ? DONE : SHIFT) :
                IDLE;
  always_comb begin
    busy = state == SHIFT;
    done = state == DONE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      saida <= '0;
      count <= '0;
      op_r  <= OP_NOP;
    end else if (accept) begin
      saida <= entrada;
      count <= n;
      op_r  <= op;
    end else if (state == SHIFT) begin
      saida <= passo;
      count <= count - SHAMT_W'(1);
    end
endmodule
